sad_fifo_bank: RTL and testbench

//  NUM_CH independent synchronous FIFOs sharing one clock, parametrised in data width and depth.

---
 rtl/sad_fifo_bank.sv | 100 ++++++++++
 tb/tb_sad_fifo_bank.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sad_fifo_bank.sv
// Bank of NUM_CH independent FIFOs feeding the SAD datapath; 1-cycle registered read, flags from next count.
// Full FIFO rejects a write unless a read happens in the same cycle; empty FIFO rejects reads (sticky errors).
module sad_fifo_bank #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int NUM_CH = 2,
    parameter int AF_LVL = 240,
    parameter int AE_LVL = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        wr,
    input  logic [NUM_CH-1:0]        rd,
    input  logic [NUM_CH-1:0]        flush,
    input  logic [NUM_CH-1:0]        err_clr,
    input  logic [NUM_CH*DATA_W-1:0] data_in,
    output logic [NUM_CH*DATA_W-1:0] data_out,
    output logic [NUM_CH-1:0]        data_valid,
    output logic [NUM_CH-1:0]        empty,
    output logic [NUM_CH-1:0]        full,
    output logic [NUM_CH-1:0]        almost_empty,
    output logic [NUM_CH-1:0]        almost_full,
    output logic [NUM_CH*CW-1:0]     count,
    output logic [NUM_CH-1:0]        overflow,
    output logic [NUM_CH-1:0]        underflow
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DATA_W-1:0] mem_q [DEPTH];
        logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
        logic [CW-1:0]     cnt_q, cnt_d;
        logic [DATA_W-1:0] dout_q;
        logic              dvld_q, empty_q, full_q, ae_q, af_q, ovf_q, unf_q;
        logic              wr_ok, rd_ok, ovf_set, unf_set;

        // A full FIFO still accepts a write when a read frees the slot in the same cycle.
        always_comb begin
            wr_ok   = wr[c] & (~full_q | rd[c]) & ~flush[c];
            rd_ok   = rd[c] & ~empty_q & ~flush[c];
            ovf_set = wr[c] & full_q & ~rd[c];
            unf_set = rd[c] & empty_q;
            cnt_d   = cnt_q + CW'(wr_ok) - CW'(rd_ok);
            if (flush[c]) begin
                cnt_d = '0;
            end
        end

        always_ff @(posedge clk) begin
            if (rst && wr_ok) begin
                mem_q[wr_ptr_q] <= data_in[c*DATA_W +: DATA_W];
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
                dout_q   <= '0;
                dvld_q   <= 1'b0;
                empty_q  <= 1'b1;
                full_q   <= 1'b0;
                ae_q     <= 1'b1;
                af_q     <= 1'b0;
                ovf_q    <= 1'b0;
                unf_q    <= 1'b0;
            end else begin
                if (flush[c]) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                end else begin
                    if (wr_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
                    if (rd_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
                end
                if (rd_ok) dout_q <= mem_q[rd_ptr_q];
                dvld_q  <= rd_ok;
                cnt_q   <= cnt_d;
                empty_q <= (cnt_d == '0);
                full_q  <= (cnt_d == CW'(DEPTH));
                ae_q    <= (cnt_d <= CW'(AE_LVL));
                af_q    <= (cnt_d >= CW'(AF_LVL));
                ovf_q   <= ovf_set | (ovf_q & ~err_clr[c]);
                unf_q   <= unf_set | (unf_q & ~err_clr[c]);
            end
        end

        assign data_out[c*DATA_W +: DATA_W] = dout_q;
        assign count[c*CW +: CW]            = cnt_q;
        assign data_valid[c]                = dvld_q;
        assign empty[c]                     = empty_q;
        assign full[c]                      = full_q;
        assign almost_empty[c]              = ae_q;
        assign almost_full[c]               = af_q;
        assign overflow[c]                  = ovf_q;
        assign underflow[c]                 = unf_q;
    end

endmodule

// File: tb/tb_sad_fifo_bank.sv
// Bench for sad_fifo_bank: default 256x8x2 instance for directed scenarios, 16x12x3 instance for random traffic.
module tb_sad_fifo_bank;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]  wr_a, rd_a, fl_a, ec_a;
    logic [15:0] din_a, dout_a;
    logic [1:0]  dv_a, em_a, fu_a, ae_a, af_a, ov_a, un_a;
    logic [17:0] cnt_a;

    logic [2:0]  wr_b, rd_b, fl_b, ec_b;
    logic [35:0] din_b, dout_b;
    logic [2:0]  dv_b, em_b, fu_b, ae_b, af_b, ov_b, un_b;
    logic [14:0] cnt_b;

    int checks = 0;
    int failures = 0;
    logic [7:0]  sb_a [2][$];
    logic [11:0] sb_b [3][$];
    logic [11:0] mq   [3][$];
    logic [2:0]  m_ov, m_un;

    sad_fifo_bank u_a (
        .clk(clk), .rst(rst), .wr(wr_a), .rd(rd_a), .flush(fl_a), .err_clr(ec_a),
        .data_in(din_a), .data_out(dout_a), .data_valid(dv_a), .empty(em_a), .full(fu_a),
        .almost_empty(ae_a), .almost_full(af_a), .count(cnt_a), .overflow(ov_a), .underflow(un_a)
    );

    sad_fifo_bank #(.DATA_W(12), .DEPTH(16), .NUM_CH(3), .AF_LVL(12), .AE_LVL(3)) u_b (
        .clk(clk), .rst(rst), .wr(wr_b), .rd(rd_b), .flush(fl_b), .err_clr(ec_b),
        .data_in(din_b), .data_out(dout_b), .data_valid(dv_b), .empty(em_b), .full(fu_b),
        .almost_empty(ae_b), .almost_full(af_b), .count(cnt_b), .overflow(ov_b), .underflow(un_b)
    );

    task automatic idle();
        wr_a = '0; rd_a = '0; fl_a = '0; ec_a = '0;
        wr_b = '0; rd_b = '0; fl_b = '0; ec_b = '0;
    endtask

    // Every expected read is pushed just before the edge that should produce it.
    task automatic tick();
        logic [7:0]  ea;
        logic [11:0] eb;
        @(posedge clk);
        #1;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (dv_a[c] !== (sb_a[c].size() != 0)) begin
                failures++;
                $display("FAIL a_valid ch%0d: got %b want %b", c, dv_a[c], sb_a[c].size() != 0);
            end
            if (sb_a[c].size() != 0) begin
                ea = sb_a[c].pop_front();
                if (dv_a[c]) begin
                    checks++;
                    if (dout_a[c*8 +: 8] !== ea) begin
                        failures++;
                        $display("FAIL a_data ch%0d: got %h want %h", c, dout_a[c*8 +: 8], ea);
                    end
                end
            end
        end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (dv_b[c] !== (sb_b[c].size() != 0)) begin
                failures++;
                $display("FAIL b_valid ch%0d: got %b want %b", c, dv_b[c], sb_b[c].size() != 0);
            end
            if (sb_b[c].size() != 0) begin
                eb = sb_b[c].pop_front();
                if (dv_b[c]) begin
                    checks++;
                    if (dout_b[c*12 +: 12] !== eb) begin
                        failures++;
                        $display("FAIL b_data ch%0d: got %h want %h", c, dout_b[c*12 +: 12], eb);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_a = 2'b01; rd_a = 2'b10; din_a = {8'h00, 8'(i + 1)};
            tick();
        end
        wr_a = 2'b01; rd_a = 2'b01; din_a = 16'h0009;
        sb_a[0].push_back(8'h01);
        tick();
        checks++;
        if (un_a !== 2'b10 || cnt_a[8:0] !== 9'd5) begin
            failures++;
            $display("FAIL pre_reset: un=%b cnt=%0d want un=10 cnt=5", un_a, cnt_a[8:0]);
        end
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if (em_a !== 2'b11 || cnt_a !== 18'd0 || dout_a !== 16'd0 || ov_a !== 2'b00 ||
            un_a !== 2'b00 || dv_a !== 2'b00 || ae_a !== 2'b11 || fu_a !== 2'b00 || af_a !== 2'b00) begin
            failures++;
            $display("FAIL async_reset: em=%b cnt=%h dout=%h ov=%b un=%b dv=%b ae=%b fu=%b af=%b",
                     em_a, cnt_a, dout_a, ov_a, un_a, dv_a, ae_a, fu_a, af_a);
        end
        checks++;
        if (em_b !== 3'b111 || cnt_b !== 15'd0 || dout_b !== 36'd0 || ov_b !== 3'b000 || un_b !== 3'b000) begin
            failures++;
            $display("FAIL b_reset: em=%b cnt=%h dout=%h", em_b, cnt_b, dout_b);
        end
        idle();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic fill_ch0();
        for (int i = 0; i < 256; i++) begin
            wr_a = 2'b01; din_a = {8'h00, 8'(i)};
            tick();
            if (i == 238 || i == 239 || i == 254 || i == 255) begin
                checks++;
                if ({fu_a[0], af_a[0], cnt_a[8:0]} !== {i == 255, i >= 239, 9'(i + 1)}) begin
                    failures++;
                    $display("FAIL fill_flags at %0d: full=%b af=%b cnt=%0d", i + 1, fu_a[0], af_a[0], cnt_a[8:0]);
                end
            end
        end
        wr_a = 2'b00;
    endtask

    task automatic test_fill_drain();
        fill_ch0();
        wr_a = 2'b01; din_a = 16'h0077;
        tick();
        wr_a = 2'b00;
        checks++;
        if (ov_a[0] !== 1'b1 || cnt_a[8:0] !== 9'd256 || fu_a[0] !== 1'b1) begin
            failures++;
            $display("FAIL overflow: ov=%b cnt=%0d full=%b want 1/256/1", ov_a[0], cnt_a[8:0], fu_a[0]);
        end
        for (int i = 0; i < 256; i++) begin
            rd_a = 2'b01;
            sb_a[0].push_back(8'(i));
            tick();
            if (i == 238 || i == 239) begin
                checks++;
                if (ae_a[0] !== (i == 239)) begin
                    failures++;
                    $display("FAIL drain_ae at cnt %0d: got %b want %b", 255 - i, ae_a[0], i == 239);
                end
            end
        end
        rd_a = 2'b00;
        checks++;
        if (em_a[0] !== 1'b1 || cnt_a[8:0] !== 9'd0 || af_a[0] !== 1'b0) begin
            failures++;
            $display("FAIL drained: em=%b cnt=%0d af=%b", em_a[0], cnt_a[8:0], af_a[0]);
        end
        ec_a = 2'b01;
        tick();
        ec_a = 2'b00;
        checks++;
        if (ov_a[0] !== 1'b0) begin
            failures++;
            $display("FAIL err_clr_ovf: got %b want 0", ov_a[0]);
        end
    endtask

    task automatic test_full_rdwr();
        fill_ch0();
        wr_a = 2'b01; rd_a = 2'b01; din_a = 16'h00AA;
        sb_a[0].push_back(8'h00);
        tick();
        wr_a = 2'b00; rd_a = 2'b00;
        checks++;
        if (cnt_a[8:0] !== 9'd256 || fu_a[0] !== 1'b1 || ov_a[0] !== 1'b0) begin
            failures++;
            $display("FAIL full_rdwr: cnt=%0d full=%b ov=%b want 256/1/0", cnt_a[8:0], fu_a[0], ov_a[0]);
        end
        for (int i = 0; i < 256; i++) begin
            rd_a = 2'b01;
            sb_a[0].push_back((i < 255) ? 8'(i + 1) : 8'hAA);
            tick();
        end
        rd_a = 2'b00;
    endtask

    task automatic test_empty_rdwr();
        wr_a = 2'b10; rd_a = 2'b10; din_a = 16'h5500;
        tick();
        checks++;
        if (cnt_a[17:9] !== 9'd1 || un_a[1] !== 1'b1 || dv_a[1] !== 1'b0 || em_a[1] !== 1'b0) begin
            failures++;
            $display("FAIL empty_rdwr: cnt=%0d un=%b dv=%b em=%b want 1/1/0/0", cnt_a[17:9], un_a[1], dv_a[1], em_a[1]);
        end
        wr_a = 2'b00;
        sb_a[1].push_back(8'h55);
        tick();
        rd_a = 2'b00; ec_a = 2'b10;
        tick();
        ec_a = 2'b00;
        checks++;
        if (un_a[1] !== 1'b0 || em_a[1] !== 1'b1) begin
            failures++;
            $display("FAIL err_clr_udf: un=%b em=%b want 0/1", un_a[1], em_a[1]);
        end
    endtask

    task automatic test_flush();
        logic [7:0] c1 [$];
        bit r1;
        for (int k = 0; k < 14; k++) begin
            r1 = (c1.size() != 0);
            if (r1) sb_a[1].push_back(c1.pop_front());
            c1.push_back(8'(8'h30 + k));
            wr_a = {1'b1, k <= 10};
            rd_a = {r1, 1'b0};
            fl_a = {1'b0, k == 10};
            din_a = {8'(8'h30 + k), (k == 10) ? 8'hEE : 8'(k)};
            tick();
            if (k == 9 || k == 10) begin
                checks++;
                if (cnt_a[8:0] !== ((k == 9) ? 9'd10 : 9'd0) || em_a[0] !== (k == 10)) begin
                    failures++;
                    $display("FAIL flush k=%0d: cnt=%0d em=%b", k, cnt_a[8:0], em_a[0]);
                end
            end
            checks++;
            if (cnt_a[17:9] !== 9'(c1.size())) begin
                failures++;
                $display("FAIL flush_ch1_cnt k=%0d: got %0d want %0d", k, cnt_a[17:9], c1.size());
            end
        end
        idle();
        while (c1.size() != 0) begin
            rd_a = 2'b10;
            sb_a[1].push_back(c1.pop_front());
            tick();
        end
        rd_a = 2'b00;
    endtask

    task automatic test_random();
        bit w, r, f, e, fm, em;
        logic [11:0] d;
        int sz;
        m_ov = '0;
        m_un = '0;
        for (int n = 0; n < 800; n++) begin
            for (int c = 0; c < 3; c++) begin
                w = (n < 400) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
                r = (n < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
                f = ($urandom_range(0, 31) == 0);
                e = ($urandom_range(0, 15) == 0);
                d = 12'($urandom);
                fm = (mq[c].size() == 16);
                em = (mq[c].size() == 0);
                m_ov[c] = (w && fm && !r) ? 1'b1 : (e ? 1'b0 : m_ov[c]);
                m_un[c] = (r && em) ? 1'b1 : (e ? 1'b0 : m_un[c]);
                if (f) begin
                    mq[c].delete();
                end else begin
                    if (r && !em) sb_b[c].push_back(mq[c].pop_front());
                    if (w && (!fm || r)) mq[c].push_back(d);
                end
                wr_b[c] = w; rd_b[c] = r; fl_b[c] = f; ec_b[c] = e;
                din_b[c*12 +: 12] = d;
            end
            tick();
            for (int c = 0; c < 3; c++) begin
                sz = mq[c].size();
                checks++;
                if ({cnt_b[c*5 +: 5], em_b[c], fu_b[c], ae_b[c], af_b[c], ov_b[c], un_b[c]} !==
                    {5'(sz), sz == 0, sz == 16, sz <= 3, sz >= 12, m_ov[c], m_un[c]}) begin
                    failures++;
                    $display("FAIL rand n=%0d ch%0d: cnt=%0d e=%b f=%b ae=%b af=%b ov=%b un=%b want cnt=%0d ov=%b un=%b",
                             n, c, cnt_b[c*5 +: 5], em_b[c], fu_b[c], ae_b[c], af_b[c], ov_b[c], un_b[c],
                             sz, m_ov[c], m_un[c]);
                end
            end
        end
        idle();
        tick();
    endtask

    initial begin
        idle();
        din_a = '0;
        din_b = '0;
        rst = 1'b0;
        test_reset();
        test_fill_drain();
        test_full_rdwr();
        test_empty_rdwr();
        test_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
